avalon_mm_arbiter: RTL and testbench
====================================

Name: avalon_mm_arbiter

Overview:
- Shares one Avalon-MM read/write agent port between the CPU instruction manager (read-only) and data manager (read/write).
- Sits between the CPU wrapper's two Avalon host ports and a single-ported memory or interconnect slave.
- Round-robin arbitration with grant lock during stalled commands.
- Tracks outstanding pipelined reads so each `readdatavalid` is returned to the host that issued the read.

Parameters:
- MAX_PENDING, 4: maximum outstanding reads in flight on the agent port (depth of the owner FIFO); power of two, ≥2.
- ADDR_W, 32: address width (`uint32_t` at default).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- i_address  in  ADDR_W  instruction host address
- i_byteenable  in  4  instruction host byte enables
- i_read  in  1  instruction host read request
- i_waitrequest  out  1  stall to instruction host
- i_agent_to_host  out  32  read data to instruction host
- i_readdatavalid  out  1  read data valid to instruction host
- d_address  in  ADDR_W  data host address
- d_byteenable  in  4  data host byte enables
- d_read  in  1  data host read request
- d_write  in  1  data host write request
- d_host_to_agent  in  32  data host write data
- d_waitrequest  out  1  stall to data host
- d_agent_to_host  out  32  read data to data host
- d_readdatavalid  out  1  read data valid to data host
- m_address  out  ADDR_W  agent address
- m_byteenable  out  4  agent byte enables
- m_read  out  1  agent read
- m_write  out  1  agent write
- m_host_to_agent  out  32  agent write data
- m_waitrequest  in  1  agent stall
- m_agent_to_host  in  32  agent read data
- m_readdatavalid  in  1  agent read data valid
- pending_count  out  $clog2(MAX_PENDING)+1  outstanding reads
- resp_error  out  1  sticky: `readdatavalid` received with no outstanding read

Behaviour:
- Reset (rst=0, async):
  - Priority pointer = instruction host; lock cleared; owner FIFO emptied; `pending_count`=0; `resp_error`=0.
  - All `m_*` command outputs are 0; both host `waitrequest` outputs are 1; both host `readdatavalid` outputs are 0.
- Requests: `req_i` = `i_read`; `req_d` = `d_read` | `d_write`. A host holding both `d_read` and `d_write` is illegal and need not be handled.
- Grant selection (combinational, zero added latency):
  - If lock is set, grant the locked host.
  - Otherwise, if only one host requests, grant it.
  - If both request, grant the host named by the priority pointer.
  - If none request, no grant; all `m_*` commands are 0.
- Command path:
  - The granted host's address, byteenable, read, write and writedata drive `m_*`.
  - Exception: `m_read` is forced to 0 while the owner FIFO is full and no pop occurs in the same cycle.
- Accept condition: granted & `m_waitrequest`=0 & command not blocked by a full FIFO.
  - Granted host `waitrequest` = !accept.
  - Non-granted host `waitrequest` = 1.
- Lock:
  - Set on a cycle where a host is granted but not accepted; held on that host.
  - Cleared on accept.
  - This guarantees Avalon command stability toward the agent.
- Priority pointer: on accept, the pointer moves to the other host. A lone requester may be granted repeatedly.
- Owner FIFO (depth MAX_PENDING, 1-bit host id):
  - Push the granted id on an accepted read; writes never push.
  - Pop on `m_readdatavalid`.
  - Simultaneous push and pop when full is allowed; count is unchanged.
  - Count updates at the clock edge.
- Response path (combinational):
  - `m_agent_to_host` is broadcast to both `*_agent_to_host` outputs.
  - `readdatavalid` is asserted only toward the FIFO-head host.
  - Responses are in order; the agent port must return reads in order.
- `m_readdatavalid` while the FIFO is empty: no host sees valid, no pop, `resp_error` set to 1 until reset.
- Writes may be accepted while reads are outstanding; no ordering is enforced between a write and earlier reads.
- Reset asserted mid-transfer: outstanding responses are forgotten. Later `m_readdatavalid` then flags `resp_error`; the system must reset the agent together with the arbiter.

Decomposition:
- Types package:
  - `host_id_t` enum {HOST_INSTR=0, HOST_DATA=1}.
  - `ARB_MAX_PENDING_DEFAULT` constant.
- Sub-module `owner_fifo`:
  - Parameterised depth, 1-bit payload, push/pop/full/empty/count.
  - Circular pointers with an extra wrap bit.
- Arbiter top: lock register, priority pointer, muxes.

Test Plan:
- Both hosts request reads at address 0x100 (instr) and 0x200 (data) every cycle, agent `waitrequest`=0, latency 2 → `m_address` alternates 0x100, 0x200; each host receives exactly its own data (agent echoes address).
- Data write to 0x40 with `m_waitrequest` held 1 for 3 cycles while the instruction host also requests → `m_*` stays on the data write all 4 cycles, `i_waitrequest`=1; instruction read is granted the cycle after accept.
- Instruction host issues 6 back-to-back reads, agent never returns data → exactly 4 accepted, `pending_count`=4, `m_read`=0 afterward; first `m_readdatavalid` lets the 5th read be accepted in that same cycle.
- Interleave instr read, data read, instr read accepted, then 3 responses 0xA, 0xB, 0xC → `i_readdatavalid` with 0xA, `d_readdatavalid` with 0xB, `i_readdatavalid` with 0xC.
- Pulse `m_readdatavalid` with the FIFO empty → neither host valid, `resp_error`=1 and stays 1 until rst=0.
- Assert rst=0 asynchronously mid-stall with 2 reads pending → `pending_count`=0, `m_read`/`m_write`=0, both host `waitrequest`=1 immediately, without a clock edge.

Source files
------------

// File: rtl/avalon_mm_arbiter_pkg.sv
// rtl/avalon_mm_arbiter_pkg.sv - shared types for the two-host Avalon-MM arbiter
package avalon_mm_arbiter_pkg;

    // Identifies which CPU host owns a command or an outstanding read.
    typedef enum logic {
        HOST_INSTR = 1'b0,
        HOST_DATA  = 1'b1
    } host_id_t;

    localparam int ARB_MAX_PENDING_DEFAULT = 4;

endpackage

// File: rtl/avalon_mm_arbiter_owner_fifo.sv
// rtl/avalon_mm_arbiter_owner_fifo.sv - in-order FIFO of host ids for outstanding reads
//
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   push, din      enqueue the id of a host whose read was accepted
//   pop, dout      dequeue on read data return; dout is the current head
//   full, empty    occupancy flags
//   count          number of entries held (0..DEPTH)
module avalon_mm_arbiter_owner_fifo
    import avalon_mm_arbiter_pkg::*;
#(
    parameter int DEPTH = ARB_MAX_PENDING_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  host_id_t                 din,
    output host_id_t                 dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    host_id_t    mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/avalon_mm_arbiter.sv
// rtl/avalon_mm_arbiter.sv - round-robin share of one Avalon-MM agent between CPU instr and data hosts
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   i_*                      instruction host (read-only) command and response
//   d_*                      data host (read/write) command and response
//   m_*                      shared agent port
//   pending_count            reads accepted on the agent port and not yet returned
//   resp_error               sticky flag: read data arrived with no read outstanding
module avalon_mm_arbiter
    import avalon_mm_arbiter_pkg::*;
#(
    parameter int MAX_PENDING = ARB_MAX_PENDING_DEFAULT,
    parameter int ADDR_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             i_address,
    input  logic [3:0]                    i_byteenable,
    input  logic                          i_read,
    output logic                          i_waitrequest,
    output logic [31:0]                   i_agent_to_host,
    output logic                          i_readdatavalid,
    input  logic [ADDR_W-1:0]             d_address,
    input  logic [3:0]                    d_byteenable,
    input  logic                          d_read,
    input  logic                          d_write,
    input  logic [31:0]                   d_host_to_agent,
    output logic                          d_waitrequest,
    output logic [31:0]                   d_agent_to_host,
    output logic                          d_readdatavalid,
    output logic [ADDR_W-1:0]             m_address,
    output logic [3:0]                    m_byteenable,
    output logic                          m_read,
    output logic                          m_write,
    output logic [31:0]                   m_host_to_agent,
    input  logic                          m_waitrequest,
    input  logic [31:0]                   m_agent_to_host,
    input  logic                          m_readdatavalid,
    output logic [$clog2(MAX_PENDING):0]  pending_count,
    output logic                          resp_error
);

    logic     req_i;
    logic     req_d;
    logic     grant_valid;
    host_id_t grant_host;
    logic     lock_q;
    host_id_t lock_host_q;
    host_id_t prio_q;
    logic     cmd_read;
    logic     read_blocked;
    logic     accept;
    logic     fifo_push;
    logic     fifo_pop;
    logic     fifo_full;
    logic     fifo_empty;
    host_id_t fifo_head;

    assign req_i = i_read;
    assign req_d = d_read || d_write;

    // Grant is purely combinational so an idle port forwards a request with no added cycle.
    // Reset forces "no grant" so every command output and stall is in its reset state
    // immediately, even while hosts keep their requests up.
    always_comb begin
        grant_valid = 1'b0;
        grant_host  = HOST_INSTR;
        if (lock_q) begin
            grant_host  = lock_host_q;
            grant_valid = (lock_host_q == HOST_DATA) ? req_d : req_i;
        end else if (req_i && req_d) begin
            grant_valid = 1'b1;
            grant_host  = prio_q;
        end else if (req_i) begin
            grant_valid = 1'b1;
            grant_host  = HOST_INSTR;
        end else if (req_d) begin
            grant_valid = 1'b1;
            grant_host  = HOST_DATA;
        end
        if (!rst) begin
            grant_valid = 1'b0;
        end
    end

    assign fifo_pop = m_readdatavalid && !fifo_empty;

    assign cmd_read     = grant_valid && ((grant_host == HOST_DATA) ? d_read : i_read);
    // Without room to record the owner, a read must not reach the agent; a pop this
    // cycle frees the slot in time.
    assign read_blocked = cmd_read && fifo_full && !fifo_pop;
    assign accept       = grant_valid && !m_waitrequest && !read_blocked;
    assign fifo_push    = accept && cmd_read;

    assign m_read          = cmd_read && !read_blocked;
    assign m_write         = grant_valid && (grant_host == HOST_DATA) && d_write;
    assign m_address       = !grant_valid ? '0 : (grant_host == HOST_DATA) ? d_address : i_address;
    assign m_byteenable    = !grant_valid ? '0 : (grant_host == HOST_DATA) ? d_byteenable : i_byteenable;
    assign m_host_to_agent = (grant_valid && grant_host == HOST_DATA) ? d_host_to_agent : '0;

    assign i_waitrequest = !(accept && grant_host == HOST_INSTR);
    assign d_waitrequest = !(accept && grant_host == HOST_DATA);

    assign i_agent_to_host = m_agent_to_host;
    assign d_agent_to_host = m_agent_to_host;
    assign i_readdatavalid = rst && fifo_pop && (fifo_head == HOST_INSTR);
    assign d_readdatavalid = rst && fifo_pop && (fifo_head == HOST_DATA);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q      <= 1'b0;
            lock_host_q <= HOST_INSTR;
            prio_q      <= HOST_INSTR;
            resp_error  <= 1'b0;
        end else begin
            // Holding the grant on a stalled command keeps m_* stable until the agent takes it.
            lock_q      <= grant_valid && !accept;
            lock_host_q <= grant_host;
            if (accept) begin
                prio_q <= (grant_host == HOST_INSTR) ? HOST_DATA : HOST_INSTR;
            end
            if (m_readdatavalid && fifo_empty) begin
                resp_error <= 1'b1;
            end
        end
    end

    avalon_mm_arbiter_owner_fifo #(
        .DEPTH (MAX_PENDING)
    ) u_owner_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (grant_host),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (pending_count)
    );

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// tb/tb_avalon_mm_arbiter.sv - directed self-checking bench for avalon_mm_arbiter
module tb_avalon_mm_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] i_address;
    logic [3:0]  i_byteenable;
    logic        i_read;
    logic        i_waitrequest;
    logic [31:0] i_agent_to_host;
    logic        i_readdatavalid;
    logic [31:0] d_address;
    logic [3:0]  d_byteenable;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_host_to_agent;
    logic        d_waitrequest;
    logic [31:0] d_agent_to_host;
    logic        d_readdatavalid;
    logic [31:0] m_address;
    logic [3:0]  m_byteenable;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_host_to_agent;
    logic        m_waitrequest;
    logic [31:0] m_agent_to_host;
    logic        m_readdatavalid;
    logic [2:0]  pending_count;
    logic        resp_error;

    int n_checks = 0;
    int n_fail   = 0;

    // Agent model: either driven by hand, or an echo agent returning the address after 2 cycles.
    logic        agent_auto;
    logic        man_rdv;
    logic [31:0] man_data;
    logic        s1_v, s2_v;
    logic [31:0] s1_a, s2_a;

    assign m_readdatavalid = agent_auto ? s2_v : man_rdv;
    assign m_agent_to_host = agent_auto ? s2_a : man_data;

    always @(posedge clk) begin
        s1_v <= agent_auto && m_read && !m_waitrequest;
        s1_a <= m_address;
        s2_v <= s1_v;
        s2_a <= s1_a;
    end

    avalon_mm_arbiter #(
        .MAX_PENDING (4),
        .ADDR_W      (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_address       (i_address),
        .i_byteenable    (i_byteenable),
        .i_read          (i_read),
        .i_waitrequest   (i_waitrequest),
        .i_agent_to_host (i_agent_to_host),
        .i_readdatavalid (i_readdatavalid),
        .d_address       (d_address),
        .d_byteenable    (d_byteenable),
        .d_read          (d_read),
        .d_write         (d_write),
        .d_host_to_agent (d_host_to_agent),
        .d_waitrequest   (d_waitrequest),
        .d_agent_to_host (d_agent_to_host),
        .d_readdatavalid (d_readdatavalid),
        .m_address       (m_address),
        .m_byteenable    (m_byteenable),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_host_to_agent (m_host_to_agent),
        .m_waitrequest   (m_waitrequest),
        .m_agent_to_host (m_agent_to_host),
        .m_readdatavalid (m_readdatavalid),
        .pending_count   (pending_count),
        .resp_error      (resp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        man_rdv = 1'b0; m_waitrequest = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; agent_auto = 1'b0; man_data = 32'h0;
        idle();
        i_read = 1'b1; d_write = 1'b1; i_address = 32'h123; d_address = 32'h456;
        i_byteenable = 4'hF; d_byteenable = 4'hF; d_host_to_agent = 32'h1111_2222;
        #12;
        n_checks++; if (m_read !== 1'b0 || m_write !== 1'b0) begin n_fail++; $display("FAIL reset_m_cmd: got rd=%b wr=%b required 0 0", m_read, m_write); end
        n_checks++; if (m_address !== 32'h0) begin n_fail++; $display("FAIL reset_m_address: got %h required 0", m_address); end
        n_checks++; if (i_waitrequest !== 1'b1 || d_waitrequest !== 1'b1) begin n_fail++; $display("FAIL reset_waitrequest: got i=%b d=%b required 1 1", i_waitrequest, d_waitrequest); end
        n_checks++; if (pending_count !== 3'd0 || resp_error !== 1'b0) begin n_fail++; $display("FAIL reset_state: got pend=%0d err=%b required 0 0", pending_count, resp_error); end
        n_checks++; if (i_readdatavalid !== 1'b0 || d_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL reset_rdv: got i=%b d=%b required 0 0", i_readdatavalid, d_readdatavalid); end
        idle();
        #3;
        rst = 1'b1;
    endtask

    task automatic test_round_robin();
        logic exp_i, exp_d;
        logic [31:0] exp_addr;
        agent_auto = 1'b1;
        i_address = 32'h100; d_address = 32'h200;
        for (int n = 0; n < 10; n++) begin
            cyc();
            i_read = (n < 8); d_read = (n < 8); m_waitrequest = 1'b0;
            #1;
            if (n < 8) begin
                exp_addr = (n % 2 == 0) ? 32'h100 : 32'h200;
                n_checks++; if (m_address !== exp_addr || m_read !== 1'b1) begin n_fail++; $display("FAIL rr_addr[%0d]: got %h rd=%b required %h rd=1", n, m_address, m_read, exp_addr); end
            end
            exp_i = (n >= 2) && ((n - 2) % 2 == 0);
            exp_d = (n >= 2) && ((n - 2) % 2 == 1);
            n_checks++; if (i_readdatavalid !== exp_i || d_readdatavalid !== exp_d) begin n_fail++; $display("FAIL rr_rdv[%0d]: got i=%b d=%b required i=%b d=%b", n, i_readdatavalid, d_readdatavalid, exp_i, exp_d); end
            if (exp_i) begin
                n_checks++; if (i_agent_to_host !== 32'h100) begin n_fail++; $display("FAIL rr_idata[%0d]: got %h required 00000100", n, i_agent_to_host); end
            end
            if (exp_d) begin
                n_checks++; if (d_agent_to_host !== 32'h200) begin n_fail++; $display("FAIL rr_ddata[%0d]: got %h required 00000200", n, d_agent_to_host); end
            end
        end
        cyc();
        #1;
        n_checks++; if (pending_count !== 3'd0) begin n_fail++; $display("FAIL rr_drained: got %0d required 0", pending_count); end
        agent_auto = 1'b0;
    endtask

    task automatic test_write_lock();
        for (int n = 0; n < 5; n++) begin
            cyc();
            d_write = (n < 4); d_address = 32'h40; d_host_to_agent = 32'hDEAD_BEEF; d_byteenable = 4'hC;
            i_read = (n >= 1); i_address = 32'h104; i_byteenable = 4'hF;
            m_waitrequest = (n < 3);
            #1;
            if (n < 4) begin
                n_checks++; if (m_write !== 1'b1 || m_read !== 1'b0 || m_address !== 32'h40) begin n_fail++; $display("FAIL lock_cmd[%0d]: got wr=%b rd=%b addr=%h required wr=1 rd=0 addr=00000040", n, m_write, m_read, m_address); end
                n_checks++; if (m_host_to_agent !== 32'hDEAD_BEEF || m_byteenable !== 4'hC) begin n_fail++; $display("FAIL lock_wdata[%0d]: got %h be=%h required deadbeef be=c", n, m_host_to_agent, m_byteenable); end
                n_checks++; if (i_waitrequest !== 1'b1 || d_waitrequest !== (n < 3)) begin n_fail++; $display("FAIL lock_wait[%0d]: got i=%b d=%b required i=1 d=%b", n, i_waitrequest, d_waitrequest, (n < 3)); end
            end else begin
                n_checks++; if (m_read !== 1'b1 || m_write !== 1'b0 || m_address !== 32'h104 || m_byteenable !== 4'hF) begin n_fail++; $display("FAIL lock_next_grant: got rd=%b wr=%b addr=%h be=%h required rd=1 wr=0 addr=00000104 be=f", m_read, m_write, m_address, m_byteenable); end
                n_checks++; if (i_waitrequest !== 1'b0 || d_waitrequest !== 1'b1) begin n_fail++; $display("FAIL lock_next_wait: got i=%b d=%b required 0 1", i_waitrequest, d_waitrequest); end
            end
        end
        cyc();
        i_read = 1'b0; man_rdv = 1'b1; man_data = 32'h5555;
        #1;
        n_checks++; if (i_readdatavalid !== 1'b1 || d_readdatavalid !== 1'b0 || i_agent_to_host !== 32'h5555) begin n_fail++; $display("FAIL lock_resp: got i=%b d=%b data=%h required 1 0 00005555", i_readdatavalid, d_readdatavalid, i_agent_to_host); end
        cyc();
        man_rdv = 1'b0;
    endtask

    task automatic test_fifo_full();
        logic       exp_acc;
        logic [2:0] exp_pc;
        for (int n = 0; n < 7; n++) begin
            cyc();
            i_read = 1'b1; i_address = 32'h300; m_waitrequest = 1'b0;
            man_rdv = (n == 6); man_data = 32'h77;
            #1;
            exp_pc  = (n < 4) ? 3'(n) : 3'd4;
            exp_acc = (n < 4) || (n == 6);
            n_checks++; if (pending_count !== exp_pc) begin n_fail++; $display("FAIL full_count[%0d]: got %0d required %0d", n, pending_count, exp_pc); end
            n_checks++; if (m_read !== exp_acc || i_waitrequest !== !exp_acc) begin n_fail++; $display("FAIL full_accept[%0d]: got rd=%b wait=%b required rd=%b wait=%b", n, m_read, i_waitrequest, exp_acc, !exp_acc); end
            if (n == 6) begin
                n_checks++; if (i_readdatavalid !== 1'b1) begin n_fail++; $display("FAIL full_pop_rdv: got %b required 1", i_readdatavalid); end
            end
        end
        for (int k = 0; k < 5; k++) begin
            cyc();
            i_read = 1'b0; man_rdv = (k < 4);
            #1;
            exp_pc = 3'(4 - k);
            n_checks++; if (pending_count !== exp_pc) begin n_fail++; $display("FAIL full_drain[%0d]: got %0d required %0d", k, pending_count, exp_pc); end
        end
        man_rdv = 1'b0;
    endtask

    task automatic test_interleave();
        logic [31:0] resp_data [3];
        logic        resp_is_d [3];
        resp_data[0] = 32'hA; resp_data[1] = 32'hB; resp_data[2] = 32'hC;
        resp_is_d[0] = 1'b0;  resp_is_d[1] = 1'b1;  resp_is_d[2] = 1'b0;
        for (int n = 0; n < 3; n++) begin
            cyc();
            i_read = !resp_is_d[n]; d_read = resp_is_d[n]; d_write = 1'b0;
            i_address = 32'h600 + 32'(n); d_address = 32'h500;
            m_waitrequest = 1'b0;
            #1;
            n_checks++; if (m_read !== 1'b1 || i_waitrequest !== resp_is_d[n] || d_waitrequest !== !resp_is_d[n]) begin n_fail++; $display("FAIL il_issue[%0d]: got rd=%b iw=%b dw=%b required rd=1 iw=%b dw=%b", n, m_read, i_waitrequest, d_waitrequest, resp_is_d[n], !resp_is_d[n]); end
        end
        for (int n = 0; n < 3; n++) begin
            cyc();
            i_read = 1'b0; d_read = 1'b0;
            man_rdv = 1'b1; man_data = resp_data[n];
            #1;
            if (n == 0) begin
                n_checks++; if (pending_count !== 3'd3) begin n_fail++; $display("FAIL il_pending: got %0d required 3", pending_count); end
            end
            n_checks++; if (i_readdatavalid !== !resp_is_d[n] || d_readdatavalid !== resp_is_d[n]) begin n_fail++; $display("FAIL il_route[%0d]: got i=%b d=%b required i=%b d=%b", n, i_readdatavalid, d_readdatavalid, !resp_is_d[n], resp_is_d[n]); end
            n_checks++; if ((resp_is_d[n] ? d_agent_to_host : i_agent_to_host) !== resp_data[n]) begin n_fail++; $display("FAIL il_data[%0d]: got %h required %h", n, resp_is_d[n] ? d_agent_to_host : i_agent_to_host, resp_data[n]); end
        end
        cyc();
        man_rdv = 1'b0;
    endtask

    task automatic test_resp_error();
        cyc();
        idle();
        man_rdv = 1'b1; man_data = 32'hBAD;
        #1;
        n_checks++; if (i_readdatavalid !== 1'b0 || d_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL err_rdv: got i=%b d=%b required 0 0", i_readdatavalid, d_readdatavalid); end
        n_checks++; if (resp_error !== 1'b0) begin n_fail++; $display("FAIL err_before_edge: got %b required 0", resp_error); end
        cyc();
        man_rdv = 1'b0;
        #1;
        n_checks++; if (resp_error !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b required 1", resp_error); end
        cyc(); cyc(); cyc();
        n_checks++; if (resp_error !== 1'b1 || pending_count !== 3'd0) begin n_fail++; $display("FAIL err_sticky: got err=%b pend=%0d required 1 0", resp_error, pending_count); end
    endtask

    task automatic test_async_reset();
        for (int n = 0; n < 2; n++) begin
            cyc();
            i_read = 1'b1; i_address = 32'h700; m_waitrequest = 1'b0;
        end
        cyc();
        i_read = 1'b0; d_write = 1'b1; d_address = 32'h80; m_waitrequest = 1'b1;
        #1;
        n_checks++; if (pending_count !== 3'd2 || m_write !== 1'b1 || d_waitrequest !== 1'b1) begin n_fail++; $display("FAIL ar_pre: got pend=%0d wr=%b dw=%b required 2 1 1", pending_count, m_write, d_waitrequest); end
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (pending_count !== 3'd0 || resp_error !== 1'b0) begin n_fail++; $display("FAIL ar_state: got pend=%0d err=%b required 0 0", pending_count, resp_error); end
        n_checks++; if (m_read !== 1'b0 || m_write !== 1'b0) begin n_fail++; $display("FAIL ar_cmd: got rd=%b wr=%b required 0 0", m_read, m_write); end
        n_checks++; if (i_waitrequest !== 1'b1 || d_waitrequest !== 1'b1) begin n_fail++; $display("FAIL ar_wait: got i=%b d=%b required 1 1", i_waitrequest, d_waitrequest); end
        cyc();
        idle();
        #2;
        rst = 1'b1;
        cyc();
        n_checks++; if (pending_count !== 3'd0 || m_write !== 1'b0) begin n_fail++; $display("FAIL ar_after: got pend=%0d wr=%b required 0 0", pending_count, m_write); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_write_lock();
        test_fifo_full();
        test_interleave();
        test_resp_error();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
